input_debounce: RTL and testbench
=================================

// Module: input_debounce
//
// PURPOSE
// - Front-end conditioner for asynchronous or noisy level inputs, WIDTH independent channels.
// - Per channel:
//   - synchronize into clk with a SYNC_STAGES flop chain;
//   - reject any level not held stable for DEBOUNCE_CYCLES consecutive clk cycles.
// - Output is a clean, glitch-free level per bit and feeds the downstream edge detector directly.
// - Rising/falling pulses therefore fire once per real transition.
//
// PARAMETERS
// - WIDTH            1      number of independent channels (1..255)
// - SYNC_STAGES      2      synchronizer depth, 2..4
// - DEBOUNCE_CYCLES  16     consecutive stable cycles required to accept a new level, 1..65535
// - INIT_VAL         '0     WIDTH-bit reset level for sync chain and outputs
//
// PORTS
// - clk      in   1      clock
// - anrst    in   1      reset, asynchronous, active-low
// - in       in   WIDTH  raw asynchronous level inputs
// - out      out  WIDTH  debounced level, registered
// - busy     out  WIDTH  channel currently qualifying a candidate level (counter != 0), registered
// - changed  out  WIDTH  1-cycle strobe, high in the cycle out[i] has just toggled, registered
//
// BEHAVIOUR
// - Reset (anrst low, asynchronous; release is synchronous to clk):
//   - every sync stage = INIT_VAL; out = INIT_VAL; busy = 0; changed = 0; counters = 0.
//   - No changed strobe on reset release, even if in != INIT_VAL.
//   - If in != INIT_VAL at release, the change is qualified normally; changed fires once when out updates.
// - Synchronizer:
//   - sync[0] <= in; sync[k] <= sync[k-1]; s = sync[SYNC_STAGES-1].
//   - No logic between stages.
// - Per-channel counter cnt, width $clog2(DEBOUNCE_CYCLES+1), every clk edge:
//   - s == out: cnt <= 0. Any mismatch gap restarts qualification.
//   - s != out and cnt == DEBOUNCE_CYCLES-1: out <= s; cnt <= 0; changed <= 1.
//   - s != out otherwise: cnt <= cnt+1.
//   - changed <= 0 in every cycle where out does not toggle.
//   - busy <= (next cnt != 0).
// - Latency:
//   - in changes and then holds. Count edge 1 as the first edge sampling the new value into sync[0].
//   - out updates on edge SYNC_STAGES + DEBOUNCE_CYCLES.
//   - changed is high for the following cycle only.
// - Glitch rejection: a pulse on in shorter than DEBOUNCE_CYCLES cycles, as seen at s, never reaches out.
// - DEBOUNCE_CYCLES = 1: out follows s with one cycle delay; busy is constantly 0.
// - Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
// - Channels are fully independent. Simultaneous transitions on several bits are qualified in parallel.
// - Reset mid-qualification: counter cleared and out forced to INIT_VAL. The partial count is discarded.
// - Internal sync flops carry the ASYNC_REG synthesis attribute.
//
// STRUCTURE
// - Package: none required.
//   - Counter-width helper $clog2(DEBOUNCE_CYCLES+1) stays local.
//   - The SYNC_STAGES and DEBOUNCE_CYCLES range limits are checked by elaboration-time assertions in this file.
// - Sub-module debounce_ch: one channel, holding sync chain, counter, out/busy/changed flops.
//   - Top level is a generate loop of WIDTH debounce_ch instances.
//   - Parameters are passed down, with INIT_VAL[i] as the per-channel init.
//
// TESTING
// - Config WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT_VAL=4'b0000 unless noted.
// - Step: in[0] 0->1 held.
//   - Expect out[0]=1 exactly 6 edges after first sampling edge.
//   - Expect changed[0] high 1 cycle; busy[0] high edges 3..5.
// - Glitch: in[1]=1 for 3 cycles, then 0.
//   - Expect out[1] stays 0, changed[1] never asserts.
//   - Expect busy[1] high then low.
// - Bounce: in[2] toggles 1,0,1,1,0,1,1,1,1.
//   - Expect counter restarts on each 0.
//   - Expect out[2] rises only after the final 4-cycle run, with one changed pulse.
// - Parallel: in=4'b1111 in one cycle.
//   - Expect all out bits rise on the same edge; changed=4'b1111 for one cycle.
// - Reset mid-operation: assert anrst low after 2 cycles of qualifying in[3]=1.
//   - Expect out/busy/changed=0 immediately (asynchronous).
//   - After release with in[3]=1 still held: out[3]=1 after full 6 edges, no pulse at release.
// - Corner: DEBOUNCE_CYCLES=1, INIT_VAL=4'b1111.
//   - Expect out=1111 after reset; in=0 gives out=0 after 3 edges; busy constantly 0.

Source files
------------

// File: rtl/debounce_ch.sv
// debounce_ch: one channel of synchronizer plus stable-level qualifier
module debounce_ch #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic INIT            = 1'b0
) (
    input  logic clk,
    input  logic anrst,
    input  logic in,
    output logic out,
    output logic busy,
    output logic changed
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
    logic          s;
    logic          toggle;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    assign s = sync[SYNC_STAGES-1];

    // accept the synchronized level once it has differed from out for DEBOUNCE_CYCLES edges
    always_comb begin
        toggle   = (s != out) && (cnt == LAST);
        cnt_next = (s == out || toggle) ? '0 : cnt + CW'(1);
    end

    // plain flop chain, nothing between stages
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) sync <= {SYNC_STAGES{INIT}};
        else        sync <= {sync[SYNC_STAGES-2:0], in};
    end

    // qualification counter and registered outputs
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            cnt     <= '0;
            out     <= INIT;
            busy    <= 1'b0;
            changed <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            out     <= toggle ? s : out;
            busy    <= cnt_next != '0;
            changed <= toggle;
        end
    end
endmodule

// File: rtl/input_debounce.sv
// input_debounce: WIDTH independent synchronize-and-debounce channels
module input_debounce #(
    parameter int               WIDTH           = 1,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] INIT_VAL        = '0
) (
    input  logic             clk,
    input  logic             anrst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] busy,
    output logic [WIDTH-1:0] changed
);
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("input_debounce: SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
        $error("input_debounce: DEBOUNCE_CYCLES must be 1..65535");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INIT           (INIT_VAL[i])
        ) u_ch (
            .clk    (clk),
            .anrst  (anrst),
            .in     (in[i]),
            .out    (out[i]),
            .busy   (busy[i]),
            .changed(changed[i])
        );
    end
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: table, hand-written and randomized checks of input_debounce
module tb_input_debounce;
    logic       clk = 1'b0;
    logic       anrst = 1'b0;
    logic [3:0] in_a = 4'h0, out_a, busy_a, chg_a;
    logic [3:0] in_b = 4'hF, out_b, busy_b, chg_b;
    int checks = 0;
    int failures = 0;

    input_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INIT_VAL(4'b0000)) dut_a (
        .clk(clk), .anrst(anrst), .in(in_a), .out(out_a), .busy(busy_a), .changed(chg_a));
    input_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .INIT_VAL(4'b1111)) dut_b (
        .clk(clk), .anrst(anrst), .in(in_b), .out(out_b), .busy(busy_b), .changed(chg_b));

    always #5 clk = ~clk;

    // reference: history of sampled inputs since reset release, and the rule
    // "out flips when the synchronized level has differed from out for DC consecutive edges"
    localparam int SS = 2;
    logic [3:0] hist [2][0:16383];
    int         n [2];
    logic [3:0] outm [2];
    logic [3:0] busym [2];
    logic [3:0] chgm [2];
    logic [3:0] initm [2];
    int         dcm [2];

    function automatic logic s_before(int d, int k, int ch);
        return (k - SS >= 1) ? hist[d][k-SS][ch] : initm[d][ch];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            n[d] = 0;
            outm[d] = initm[d];
            busym[d] = 4'h0;
            chgm[d] = 4'h0;
        end
    endtask

    task automatic model_edge(input int d, input logic [3:0] in_now);
        logic [3:0] nxt;
        n[d]++;
        hist[d][n[d]] = in_now;
        nxt = outm[d];
        for (int ch = 0; ch < 4; ch++) begin
            int r = 0;
            while (r < dcm[d] && n[d] - r >= 1 && s_before(d, n[d] - r, ch) != outm[d][ch]) r++;
            chgm[d][ch]  = (r == dcm[d]);
            busym[d][ch] = (r > 0) && (r < dcm[d]);
            if (r == dcm[d]) nxt[ch] = ~outm[d][ch];
        end
        outm[d] = nxt;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("model_out_a", out_a, outm[0]);
        chk("model_busy_a", busy_a, busym[0]);
        chk("model_chg_a", chg_a, chgm[0]);
        chk("model_out_b", out_b, outm[1]);
        chk("model_busy_b", busy_b, busym[1]);
        chk("model_chg_b", chg_b, chgm[1]);
    endtask

    // one clock edge: advance the model at the edge, compare at the following negedge
    task automatic tick();
        @(posedge clk);
        if (anrst) begin
            model_edge(0, in_a);
            model_edge(1, in_b);
        end
        @(negedge clk);
        chk_model();
    endtask

    task automatic settle(input logic [3:0] v, input int cycles);
        in_a = v;
        repeat (cycles) tick();
    endtask

    typedef struct {
        logic [3:0] in;
        logic [3:0] out;
        logic [3:0] busy;
        logic [3:0] chg;
        bit         settle_after;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic [3:0] i, logic [3:0] o, logic [3:0] b, logic [3:0] c, bit s = 0);
        vec_t v;
        v.in = i; v.out = o; v.busy = b; v.chg = c; v.settle_after = s;
        tbl.push_back(v);
    endfunction

    initial begin
        dcm[0] = 4; initm[0] = 4'h0;
        dcm[1] = 1; initm[1] = 4'hF;
        model_reset();

        // step on in[0]: out rises on edge 6, busy edges 3..5, then back to 0
        add(4'h1, 4'h0, 4'h0, 4'h0); add(4'h1, 4'h0, 4'h0, 4'h0);
        add(4'h1, 4'h0, 4'h1, 4'h0); add(4'h1, 4'h0, 4'h1, 4'h0);
        add(4'h1, 4'h0, 4'h1, 4'h0); add(4'h1, 4'h1, 4'h0, 4'h1);
        add(4'h1, 4'h1, 4'h0, 4'h0); add(4'h0, 4'h1, 4'h0, 4'h0);
        add(4'h0, 4'h1, 4'h0, 4'h0); add(4'h0, 4'h1, 4'h1, 4'h0);
        add(4'h0, 4'h1, 4'h1, 4'h0); add(4'h0, 4'h1, 4'h1, 4'h0);
        add(4'h0, 4'h0, 4'h0, 4'h1); add(4'h0, 4'h0, 4'h0, 4'h0, 1);
        // 3-cycle glitch on in[1]
        add(4'h2, 4'h0, 4'h0, 4'h0); add(4'h2, 4'h0, 4'h0, 4'h0);
        add(4'h2, 4'h0, 4'h2, 4'h0); add(4'h0, 4'h0, 4'h2, 4'h0);
        add(4'h0, 4'h0, 4'h2, 4'h0); add(4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1);
        // bounce on in[2]: 1,0,1,1,0,1,1,1,1 then held
        add(4'h4, 4'h0, 4'h0, 4'h0); add(4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h4, 4'h0, 4'h4, 4'h0); add(4'h4, 4'h0, 4'h0, 4'h0);
        add(4'h0, 4'h0, 4'h4, 4'h0); add(4'h4, 4'h0, 4'h4, 4'h0);
        add(4'h4, 4'h0, 4'h0, 4'h0); add(4'h4, 4'h0, 4'h4, 4'h0);
        add(4'h4, 4'h0, 4'h4, 4'h0); add(4'h4, 4'h0, 4'h4, 4'h0);
        add(4'h4, 4'h4, 4'h0, 4'h4); add(4'h4, 4'h4, 4'h0, 4'h0, 1);
        // all channels at once
        add(4'hF, 4'h0, 4'h0, 4'h0); add(4'hF, 4'h0, 4'h0, 4'h0);
        add(4'hF, 4'h0, 4'hF, 4'h0); add(4'hF, 4'h0, 4'hF, 4'h0);
        add(4'hF, 4'h0, 4'hF, 4'h0); add(4'hF, 4'hF, 4'h0, 4'hF);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_a", out_a, 4'h0);
        chk("rst_busy_a", busy_a, 4'h0);
        chk("rst_chg_a", chg_a, 4'h0);
        chk("rst_out_b", out_b, 4'hF);
        chk("rst_busy_b", busy_b, 4'h0);
        anrst = 1'b1;
        settle(4'h0, 4);

        foreach (tbl[k]) begin
            in_a = tbl[k].in;
            tick();
            chk($sformatf("tbl%0d_out", k), out_a, tbl[k].out);
            chk($sformatf("tbl%0d_busy", k), busy_a, tbl[k].busy);
            chk($sformatf("tbl%0d_chg", k), chg_a, tbl[k].chg);
            if (tbl[k].settle_after) settle(4'h0, 8);
        end

        // reset mid-qualification of in[3], with out[0] already high
        settle(4'h1, 8);
        chk("pre_rst_out", out_a, 4'h1);
        in_a = 4'h9;
        repeat (4) tick();
        chk("pre_rst_busy", busy_a, 4'h8);
        #2 anrst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_out", out_a, 4'h0);
        chk("async_rst_busy", busy_a, 4'h0);
        chk("async_rst_chg", chg_a, 4'h0);
        chk("async_rst_out_b", out_b, 4'hF);
        tick();
        anrst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("release_e%0d_out", e), out_a, 4'h0);
            chk($sformatf("release_e%0d_chg", e), chg_a, 4'h0);
        end
        tick();
        chk("release_e6_out", out_a, 4'h9);
        chk("release_e6_chg", chg_a, 4'h9);
        tick();
        chk("release_e7_chg", chg_a, 4'h0);

        // DEBOUNCE_CYCLES=1, INIT all ones: in=0 reaches out on edge 3
        in_b = 4'h0;
        tick(); chk("dc1_e1_out", out_b, 4'hF);
        tick(); chk("dc1_e2_out", out_b, 4'hF);
        tick(); chk("dc1_e3_out", out_b, 4'h0);
        chk("dc1_e3_chg", chg_b, 4'hF);
        chk("dc1_e3_busy", busy_b, 4'h0);
        tick(); chk("dc1_e4_chg", chg_b, 4'h0);

        // randomized level changes against the reference model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) in_a = 4'($urandom);
            if ($urandom_range(0, 2) == 0) in_b = 4'($urandom);
            tick();
            if (busy_b !== 4'h0) chk("dc1_busy_zero", busy_b, 4'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
